// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 slave exposing a parametrised register file with burst read/write.
// Pins are synchronised into clk_i; all protocol decisions use the synchronised edges.
module spi_regfile #(
  parameter int NUM_REGS = 8,
  parameter int REG_WIDTH = 8,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUES = '0,
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          spi_sclk_i,
  input  logic                          spi_mosi_i,
  input  logic                          spi_cs_ni,
  output logic                          spi_miso_o,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
  output logic                          wr_strobe_o,
  output logic [AW-1:0]                 wr_addr_o
);
  localparam int SW = REG_WIDTH > 8 ? REG_WIDTH : 8;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DROP} state_t;
  state_t state, state_nx;

  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic [SW-1:0] sh_in, sh_nx;
  logic [REG_WIDTH-1:0] sh_out, wr_data;
  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [5:0] cnt;
  logic [AW-1:0] addr, addr_inc, cmd_addr;
  logic skip, rise, fall, cs_fall, active, last, cmd_done, wr_done, rd_done, bad;

  assign rise     = enable_i & sclk_q[1] & ~sclk_q[2];
  assign fall     = enable_i & ~sclk_q[1] & sclk_q[2];
  assign cs_fall  = enable_i & ~cs_q[1] & cs_q[2];
  assign sh_nx    = {sh_in[SW-2:0], mosi_q[1]};
  assign active   = (state == CMD) | (state == WDATA) | (state == RDATA);
  assign last     = rise & active & (cnt == ((state == CMD) ? 6'd7 : 6'(REG_WIDTH - 1)));
  assign cmd_done = last & (state == CMD);
  assign wr_done  = last & (state == WDATA);
  assign rd_done  = last & (state == RDATA);
  assign cmd_addr = sh_nx[AW-1:0];
  assign bad      = int'(sh_nx[6:0]) >= NUM_REGS;
  assign addr_inc = (addr == AW'(NUM_REGS - 1)) ? '0 : addr + 1'b1;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_o[i*REG_WIDTH +: REG_WIDTH] = regs[i];
  end

  // CS high always wins, even while disabled, so a dropped frame never lingers
  always_comb
    state_nx = cs_q[1] ? IDLE
             : (state == IDLE && cs_fall) ? CMD
             : cmd_done ? (bad ? DROP : (sh_nx[7] ? RDATA : WDATA))
             : state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      sh_in       <= '0;
      sh_out      <= '0;
      wr_data     <= '0;
      cnt         <= '0;
      addr        <= '0;
      skip        <= 1'b0;
      spi_miso_o  <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUES[i*REG_WIDTH +: REG_WIDTH];
    end else begin
      sclk_q      <= {sclk_q[1:0], spi_sclk_i};
      cs_q        <= {cs_q[1:0], spi_cs_ni};
      mosi_q      <= {mosi_q[0], spi_mosi_i};
      spi_miso_o  <= (state == RDATA) & sh_out[REG_WIDTH-1];
      wr_strobe_o <= wr_done;
      if (wr_strobe_o) regs[wr_addr_o] <= wr_data;
      if (state == IDLE) cnt <= '0;
      else if (rise && active) begin
        sh_in <= sh_nx;
        cnt   <= last ? '0 : cnt + 6'd1;
      end
      if (cmd_done) begin
        addr   <= cmd_addr;
        sh_out <= regs[cmd_addr];
        skip   <= 1'b1;
      end
      if (wr_done) begin
        wr_data   <= sh_nx[REG_WIDTH-1:0];
        wr_addr_o <= addr;
        addr      <= addr_inc;
      end
      // a freshly loaded word must survive the next falling edge so its MSB is sampled
      if (rd_done) begin
        addr   <= addr_inc;
        sh_out <= regs[addr_inc];
        skip   <= 1'b1;
      end else if (fall && state == RDATA) begin
        skip <= 1'b0;
        if (!skip) sh_out <= sh_out << 1;
      end
    end
  end
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: directed and randomised SPI frames against a register-array/write-queue model.
module tb_spi_regfile;
  localparam int N = 8, W = 8, H = 6;
  localparam logic [N*W-1:0] RV = 64'h0007060504030201;

  logic clk_i = 0, rst_ni = 0, enable_i = 1, sclk = 0, mosi = 0, cs_n = 1;
  logic miso, wr_strobe;
  logic [N*W-1:0] regs;
  logic [2:0] wr_addr;

  int tests = 0, fails = 0, strobes = 0;
  logic [7:0] model [N];
  logic [7:0] committed [N];
  logic [10:0] exp_wr [$];
  logic [7:0] rd_got [$];
  bit rd_phase = 0;

  always #5 clk_i = ~clk_i;

  spi_regfile #(.NUM_REGS(N), .REG_WIDTH(W), .RESET_VALUES(RV)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .spi_sclk_i(sclk),
    .spi_mosi_i(mosi), .spi_cs_ni(cs_n), .spi_miso_o(miso), .regs_o(regs),
    .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: regs_o against committed writes, strobe address against the queue
  always @(negedge clk_i) begin
    logic [N*W-1:0] e;
    logic [10:0] p;
    for (int i = 0; i < N; i++) e[i*W +: W] = committed[i];
    check("regs_o", regs, e);
    if (!rd_phase) check("miso_quiet", miso, 0);
    if (wr_strobe) begin
      strobes++;
      tests++;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got strobe addr %0d expected none at %0t", wr_addr, $time);
      end else begin
        p = exp_wr.pop_front();
        check("wr_addr_o", wr_addr, p[10:8]);
        committed[p[10:8]] = p[7:0];
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(H);
      rx = {rx[6:0], miso};
      sclk = 1;
      wait_clk(H);
      sclk = 0;
    end
  endtask

  task automatic load_model_reset();
    for (int i = 0; i < N; i++) begin
      model[i] = RV[i*W +: W];
      committed[i] = RV[i*W +: W];
    end
    exp_wr.delete();
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] data [$], input int tail, input bit en);
    logic [7:0] rx, ex;
    logic [6:0] a;
    bit live;
    a = cmd[6:0];
    live = en && (a < N);
    rd_got.delete();
    enable_i = en;
    rd_phase = live && cmd[7];
    cs_n = 0;
    wait_clk(H);
    xfer(cmd, 8, rx);
    foreach (data[j]) begin
      ex = model[a[2:0]];
      if (live && !cmd[7]) begin
        exp_wr.push_back({a[2:0], data[j]});
        model[a[2:0]] = data[j];
      end
      xfer(data[j], 8, rx);
      if (live && cmd[7]) begin
        rd_got.push_back(rx);
        check("read_word", rx, ex);
      end
      a = (a == N - 1) ? 7'd0 : a + 7'd1;
    end
    if (tail > 0) xfer(8'($urandom), tail, rx);
    wait_clk(H);
    cs_n = 1;
    wait_clk(2 * H);
    rd_phase = 0;
    enable_i = 1;
    check("writes_drained", exp_wr.size(), 0);
  endtask

  initial begin
    logic [7:0] d [$];
    logic [7:0] rx;
    int s0;
    load_model_reset();
    wait_clk(3);
    check("rst_regs", regs, RV);
    check("rst_miso", miso, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_addr", wr_addr, 0);
    rst_ni = 1;
    wait_clk(4);

    s0 = strobes;
    d.delete(); d.push_back(8'hA5);
    frame(8'h03, d, 0, 1);
    check("single_strobes", strobes - s0, 1);
    check("single_reg3", regs[3*W +: W], 8'hA5);
    check("single_all", regs, 64'h00070605A5030201);

    s0 = strobes;
    d.delete(); d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
    frame(8'h06, d, 0, 1);
    check("burst_strobes", strobes - s0, 3);
    check("burst_all", regs, 64'h22110605A5030233);

    s0 = strobes;
    d.delete(); d.push_back(8'h00); d.push_back(8'h00); d.push_back(8'h00);
    frame(8'h86, d, 0, 1);
    check("read_strobes", strobes - s0, 0);
    check("read_b0", rd_got[0], 8'h11);
    check("read_b1", rd_got[1], 8'h22);
    check("read_b2", rd_got[2], 8'h33);

    s0 = strobes;
    d.delete();
    frame(8'h02, d, 5, 1);
    check("abort_strobes", strobes - s0, 0);
    check("abort_reg2", regs[2*W +: W], 8'h03);

    s0 = strobes;
    d.delete(); d.push_back(8'hFF);
    frame(8'h7F, d, 0, 1);
    check("drop_strobes", strobes - s0, 0);

    s0 = strobes;
    d.delete(); d.push_back(8'h5A);
    frame(8'h01, d, 0, 0);
    check("disabled_strobes", strobes - s0, 0);
    check("disabled_reg1", regs[1*W +: W], 8'h02);
    frame(8'h01, d, 0, 1);
    check("enabled_reg1", regs[1*W +: W], 8'h5A);

    cs_n = 0;
    wait_clk(H);
    xfer(8'h04, 8, rx);
    xfer(8'h77, 5, rx);
    rst_ni = 0;
    load_model_reset();
    wait_clk(2);
    check("midrst_regs", regs, RV);
    check("midrst_miso", miso, 0);
    check("midrst_strobe", wr_strobe, 0);
    check("midrst_addr", wr_addr, 0);
    cs_n = 1;
    sclk = 0;
    wait_clk(4);
    rst_ni = 1;
    wait_clk(4);

    for (int f = 0; f < 40; f++) begin
      logic [7:0] cmd;
      int nw, tail;
      bit en;
      cmd[7] = 1'($urandom_range(0, 1));
      cmd[6:0] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 9));
      en = $urandom_range(0, 5) != 0;
      nw = $urandom_range(0, 3);
      tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      d.delete();
      for (int k = 0; k < nw; k++) d.push_back(8'($urandom));
      frame(cmd, d, tail, en);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
